// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the halt opcode and its field position, the bubble word, the run-control
// state encoding, the next-PC source selector and a halt-word helper.
package instruction_fetch_pkg;

    localparam logic [3:0]  OPC_HALT = 4'b1111;
    localparam int          OPC_MSB  = 15;
    localparam int          OPC_LSB  = 12;
    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_RESET
    } pc_sel_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB] == OPC_HALT;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_next_mux.sv
// Next-PC selector for the fetch stage (purely combinational).
// Ports:
//   sel           which source drives next_pc (hold/inc/branch/jump/reset)
//   fetch_pc      current fetch address
//   instr_pc      PC of the word in the IR (branch base)
//   branch_offset signed word offset, relative to instr_pc+1
//   jump_target   absolute redirect address
//   next_pc       selected address; wraps mod 2^PC_WIDTH
module instruction_fetch_pc_next_mux
    import instruction_fetch_pkg::*;
#(
    parameter int                   PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  pc_sel_t              sel,
    input  logic [PC_WIDTH-1:0]  fetch_pc,
    input  logic [PC_WIDTH-1:0]  instr_pc,
    input  logic [7:0]           branch_offset,
    input  logic [PC_WIDTH-1:0]  jump_target,
    output logic [PC_WIDTH-1:0]  next_pc
);

    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] branch_pc;

    // Sized cast of a signed operand sign-extends; the sum truncates so it wraps.
    assign offset_ext = PC_WIDTH'($signed(branch_offset));
    assign branch_pc  = instr_pc + PC_WIDTH'(1) + offset_ext;

    always_comb begin
        next_pc = fetch_pc;
        case (sel)
            SEL_HOLD:   next_pc = fetch_pc;
            SEL_INC:    next_pc = fetch_pc + PC_WIDTH'(1);
            SEL_BRANCH: next_pc = branch_pc;
            SEL_JUMP:   next_pc = jump_target;
            SEL_RESET:  next_pc = RESET_PC;
            default:    next_pc = fetch_pc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage feeding the decoder.
// Drives a synchronous ROM (1-cycle latency) with imem_addr = next_pc, registers
// the returned word into the IR with a valid bit and its PC, and handles stall,
// branch/jump redirect (one bubble), start/halt run control and a fetch counter.
//
//   state | meaning
//   IDLE  | after reset; PC parked, IR bubbles, waiting for start
//   RUN   | fetching sequentially, honouring stall and redirect
//   HALT  | halt word seen; PC parked on it, waiting for start to resume
//
// Ports:
//   clk, rst_n (sync, active-low), start, stall
//   branch_taken, branch_offset, jump_en, jump_target : redirect from the IR word
//   imem_addr / imem_rdata : ROM address (combinational) and data
//   instr, instr_valid, instr_pc : IR contents to the decoder
//   halted, fetch_count : status
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                   PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [7:0]           branch_offset,
    input  logic                 jump_en,
    input  logic [PC_WIDTH-1:0]  jump_target,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [15:0]          imem_rdata,
    output logic [15:0]          instr,
    output logic                 instr_valid,
    output logic [PC_WIDTH-1:0]  instr_pc,
    output logic                 halted,
    output logic [15:0]          fetch_count
);

    fetch_state_t        state, state_nxt;
    pc_sel_t             pc_sel;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] next_pc;
    logic                redirect;
    logic                ir_load;
    logic                ir_bubble;
    logic                count_inc;

    // Redirect only trusts the IR when it holds a real instruction.
    assign redirect = instr_valid && (jump_en || branch_taken);

    always_comb begin
        state_nxt = state;
        pc_sel    = SEL_HOLD;
        ir_load   = 1'b0;
        ir_bubble = 1'b0;
        count_inc = 1'b0;
        if (!rst_n) begin
            pc_sel = SEL_RESET;
        end else begin
            case (state)
                IDLE: begin
                    ir_bubble = 1'b1;
                    if (start) begin
                        state_nxt = RUN;
                        pc_sel    = SEL_RESET;
                    end
                end
                RUN: begin
                    if (stall) begin
                        pc_sel = SEL_HOLD;
                    end else if (redirect) begin
                        // Wrong-path word at fetch_pc (even a halt word) is dropped.
                        ir_bubble = 1'b1;
                        pc_sel    = jump_en ? SEL_JUMP : SEL_BRANCH;
                    end else if (is_halt(imem_rdata)) begin
                        ir_bubble = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        ir_load   = 1'b1;
                        count_inc = 1'b1;
                        pc_sel    = SEL_INC;
                    end
                end
                HALT: begin
                    ir_bubble = 1'b1;
                    if (start) begin
                        state_nxt = RUN;
                        pc_sel    = SEL_INC;
                    end
                end
                default: begin
                    ir_bubble = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    instruction_fetch_pc_next_mux #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_next_mux (
        .sel           (pc_sel),
        .fetch_pc      (fetch_pc),
        .instr_pc      (instr_pc),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .next_pc       (next_pc)
    );

    assign imem_addr = next_pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            fetch_pc <= next_pc;
            if (ir_load) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
                instr_pc    <= fetch_pc;
            end else if (ir_bubble) begin
                instr       <= NOP_WORD;
                instr_valid <= 1'b0;
            end
            if (count_inc && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

endmodule
